// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// N-master to 1-slave arbiter for the SRAM-like (req/addr_ok/data_ok) bus.
// A combinational grant picks one requesting master and forwards its request
// to the slave. Each request the slave accepts records its owner in a small
// FIFO. Responses pop that FIFO in order and are steered back to the owner.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   m_req/m_wr/m_size/m_addr/m_wstrb/m_wdata
//                        packed per-master request fields (master i at slice i)
//   m_addr_ok            one-hot: the granted master's request was accepted
//   m_data_ok            one-hot: response for the master at the FIFO head
//   m_rdata              slave read data, broadcast to all masters
//   s_req..s_wdata       request forwarded to the slave
//   s_addr_ok/s_data_ok  slave accept / response strobes
//   s_rdata              slave read data
//   outstanding          accepted requests still awaiting a response
//   proto_err            sticky: the slave responded with nothing outstanding
module sram_like_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [2*NUM_MASTERS-1:0]          m_size,
    input  logic [ADDR_W*NUM_MASTERS-1:0]     m_addr,
    input  logic [(DATA_W/8)*NUM_MASTERS-1:0] m_wstrb,
    input  logic [DATA_W*NUM_MASTERS-1:0]     m_wdata,
    output logic [NUM_MASTERS-1:0]            m_addr_ok,
    output logic [NUM_MASTERS-1:0]            m_data_ok,
    output logic [DATA_W-1:0]                 m_rdata,
    output logic                              s_req,
    output logic                              s_wr,
    output logic [1:0]                        s_size,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic [DATA_W/8-1:0]               s_wstrb,
    output logic [DATA_W-1:0]                 s_wdata,
    input  logic                              s_addr_ok,
    input  logic                              s_data_ok,
    input  logic [DATA_W-1:0]                 s_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              proto_err
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int STRB_W = DATA_W / 8;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] grant;
    logic             grant_valid;
    logic [IDX_W:0]   cand;

    logic [IDX_W-1:0] owner_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] head_owner;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             respond;

    // Grant search: walk the masters starting at the base index and wrap
    // modulo NUM_MASTERS. Fixed-priority mode always starts at master 0.
    always_comb begin
        base        = (ARB_MODE == 1) ? '0 : rr_ptr;
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, base} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!grant_valid && m_req[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = cand[IDX_W-1:0];
            end
        end
    end

    // Full is a wrapped write pointer sitting on the read pointer; the
    // extra pointer MSB tells full apart from empty.
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head_owner = owner_mem[rd_ptr[PTR_W-2:0]];
    assign outstanding = wr_ptr - rd_ptr;

    // A full FIFO blocks new requests even if a pop happens this cycle, so
    // the slave never sees more than MAX_OUTSTANDING requests in flight.
    assign s_req   = grant_valid & ~fifo_full & resetn;
    assign accept  = s_req & s_addr_ok;
    assign respond = s_data_ok & ~fifo_empty;

    // Forward the granted master's payload; idle bus drives zeros.
    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wstrb = '0;
        s_wdata = '0;
        if (grant_valid) begin
            s_wr    = m_wr[grant];
            s_size  = m_size[int'(grant)*2 +: 2];
            s_addr  = m_addr[int'(grant)*ADDR_W +: ADDR_W];
            s_wstrb = m_wstrb[int'(grant)*STRB_W +: STRB_W];
            s_wdata = m_wdata[int'(grant)*DATA_W +: DATA_W];
        end
    end

    // Steer the accept and response strobes back to their masters.
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        m_rdata   = '0;
        if (accept) begin
            m_addr_ok[grant] = 1'b1;
        end
        if (respond) begin
            m_data_ok[head_owner] = 1'b1;
            m_rdata               = s_rdata;
        end
    end

    // Owner storage needs no reset: entries are only read between a push
    // and its matching pop.
    always_ff @(posedge clk) begin
        if (accept) begin
            owner_mem[wr_ptr[PTR_W-2:0]] <= grant;
        end
    end

    // Pointer and status registers. The round-robin pointer moves just past
    // the master that won an accepted request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (ARB_MODE == 0) begin
                    rr_ptr <= (grant == IDX_W'(NUM_MASTERS-1)) ? '0 : grant + 1'b1;
                end
            end
            if (respond) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (s_data_ok && fifo_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter.
// Main instance: 3 masters, round-robin, depth 4, random masters and slave.
// Second instance: fixed priority, always-accepting slave answering next cycle.
module tb_sram_like_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic resetn;

    logic [N-1:0]    m_req, m_wr;
    logic [2*N-1:0]  m_size;
    logic [AW*N-1:0] m_addr;
    logic [SW*N-1:0] m_wstrb;
    logic [DW*N-1:0] m_wdata;

    logic [N-1:0]  m_addr_ok, m_data_ok;
    logic [DW-1:0] m_rdata;
    logic          s_req, s_wr;
    logic [1:0]    s_size;
    logic [AW-1:0] s_addr;
    logic [SW-1:0] s_wstrb;
    logic [DW-1:0] s_wdata;
    logic          s_addr_ok, s_data_ok;
    logic [DW-1:0] s_rdata;
    logic [2:0]    outstanding;
    logic          proto_err;

    logic [N-1:0]  f_m_addr_ok, f_m_data_ok;
    logic [DW-1:0] f_m_rdata;
    logic          f_s_req, f_s_wr;
    logic [1:0]    f_s_size;
    logic [AW-1:0] f_s_addr;
    logic [SW-1:0] f_s_wstrb;
    logic [DW-1:0] f_s_wdata;
    logic          f_s_data_ok;
    logic [DW-1:0] f_s_rdata;
    logic [2:0]    f_outstanding;
    logic          f_proto_err;

    int n_checks = 0;
    int n_errors = 0;

    // Master state: a master holds its request until the model grants it.
    logic        mst_busy  [N];
    logic        mst_wr    [N];
    logic [1:0]  mst_size  [N];
    logic [31:0] mst_addr  [N];
    logic [3:0]  mst_wstrb [N];
    logic [31:0] mst_wdata [N];

    // Reference model state.
    int ref_ptr = 0;
    int owner_q[$];
    int acc_q[$];
    typedef struct {
        int          owner;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t rsp_q[$];

    logic        fix_pending = 1'b0;
    int          fix_owner = 0;
    logic [N-1:0] fix_exp_aok, fix_exp_dok;
    logic [31:0] fix_exp_rdata;

    logic        mon_en = 1'b0;
    logic        exp_sreq, exp_acc, exp_rsp;
    logic [2:0]  exp_out;
    logic [31:0] exp_s_addr;
    logic [38:0] exp_s_rest;

    sram_like_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
        .MAX_OUTSTANDING(MO), .ARB_MODE(0)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    sram_like_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
        .MAX_OUTSTANDING(MO), .ARB_MODE(1)
    ) dut_fix (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata),
        .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_addr(f_s_addr),
        .s_wstrb(f_s_wstrb), .s_wdata(f_s_wdata),
        .s_addr_ok(1'b1), .s_data_ok(f_s_data_ok), .s_rdata(f_s_rdata),
        .outstanding(f_outstanding), .proto_err(f_proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of random stimulus; the model predicts this cycle's outputs
    // from the arbitration rules and then advances its own state.
    task automatic applyStimulus(input int p_new, input int p_aok, input int p_dok);
        int g, fg, idx;
        rsp_t r;
        for (int i = 0; i < N; i++) begin
            if (!mst_busy[i] && $urandom_range(99) < p_new) begin
                mst_busy[i]  = 1'b1;
                mst_wr[i]    = 1'($urandom_range(1));
                mst_size[i]  = 2'($urandom_range(2));
                mst_addr[i]  = $urandom;
                mst_wstrb[i] = 4'($urandom);
                mst_wdata[i] = $urandom;
            end
            m_req[i]            = mst_busy[i];
            m_wr[i]             = mst_wr[i];
            m_size[2*i +: 2]    = mst_size[i];
            m_addr[AW*i +: AW]  = mst_addr[i];
            m_wstrb[SW*i +: SW] = mst_wstrb[i];
            m_wdata[DW*i +: DW] = mst_wdata[i];
        end
        s_addr_ok = ($urandom_range(99) < p_aok);
        s_data_ok = (owner_q.size() > 0) && ($urandom_range(99) < p_dok);
        s_rdata   = $urandom;

        g  = -1;
        fg = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ref_ptr + k) % N;
            if (g < 0 && mst_busy[idx]) g = idx;
            if (fg < 0 && mst_busy[k]) fg = k;
        end
        exp_sreq   = (g >= 0) && (owner_q.size() < MO);
        exp_out    = 3'(owner_q.size());
        exp_acc    = exp_sreq && s_addr_ok;
        exp_rsp    = s_data_ok;
        exp_s_addr = (g >= 0) ? mst_addr[g] : '0;
        exp_s_rest = (g >= 0) ? {mst_wr[g], mst_size[g], mst_wstrb[g], mst_wdata[g]} : '0;

        if (exp_rsp) begin
            r.owner = owner_q.pop_front();
            r.rdata = s_rdata;
            rsp_q.push_back(r);
        end
        if (exp_acc) begin
            acc_q.push_back(g);
            owner_q.push_back(g);
            mst_busy[g] = 1'b0;
            ref_ptr     = (g + 1) % N;
        end

        f_s_data_ok   = fix_pending;
        f_s_rdata     = $urandom;
        fix_exp_dok   = fix_pending ? onehot(fix_owner) : '0;
        fix_exp_rdata = f_s_rdata;
        fix_exp_aok   = (fg >= 0) ? onehot(fg) : '0;
        fix_pending   = (fg >= 0);
        fix_owner     = (fg >= 0) ? fg : 0;
    endtask

    // Monitor: compares per-cycle outputs and pops the scoreboard queues
    // whenever the DUT presents an accept or a response.
    always @(negedge clk) begin : monitor
        int   ag;
        rsp_t rr;
        if (mon_en) begin
            checkOutput("s_req", s_req, exp_sreq);
            checkOutput("outstanding", outstanding, exp_out);
            checkOutput("proto_err_idle", proto_err, 0);
            checkOutput("s_addr", s_addr, exp_s_addr);
            checkOutput("s_payload", {s_wr, s_size, s_wstrb, s_wdata}, exp_s_rest);
            checkOutput("addr_ok_present", |m_addr_ok, exp_acc);
            checkOutput("data_ok_present", |m_data_ok, exp_rsp);
            if (m_addr_ok != '0) begin
                if (acc_q.size() == 0) begin
                    checkOutput("unexpected_addr_ok", m_addr_ok, 0);
                end else begin
                    ag = acc_q.pop_front();
                    checkOutput("addr_ok_owner", m_addr_ok, onehot(ag));
                end
            end
            if (m_data_ok != '0) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_data_ok", m_data_ok, 0);
                end else begin
                    rr = rsp_q.pop_front();
                    checkOutput("data_ok_owner", m_data_ok, onehot(rr.owner));
                    checkOutput("m_rdata", m_rdata, rr.rdata);
                end
            end
            checkOutput("fix_addr_ok", f_m_addr_ok, fix_exp_aok);
            checkOutput("fix_data_ok", f_m_data_ok, fix_exp_dok);
            if (fix_exp_dok != '0) begin
                checkOutput("fix_rdata", f_m_rdata, fix_exp_rdata);
            end
        end
    end

    task automatic clearModel();
        for (int i = 0; i < N; i++) mst_busy[i] = 1'b0;
        owner_q.delete();
        acc_q.delete();
        rsp_q.delete();
        ref_ptr     = 0;
        fix_pending = 1'b0;
        m_req       = '0;
        s_addr_ok   = 1'b0;
        s_data_ok   = 1'b0;
        f_s_data_ok = 1'b0;
    endtask

    function automatic logic anyBusy();
        logic b;
        b = 1'b0;
        for (int i = 0; i < N; i++) b = b | mst_busy[i];
        return b;
    endfunction

    initial begin
        resetn  = 1'b1;
        m_wr    = '0;
        m_size  = '0;
        m_addr  = '0;
        m_wstrb = '0;
        m_wdata = '0;
        s_rdata = '0;
        f_s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            mst_busy[i] = 1'b0; mst_wr[i] = 1'b0; mst_size[i] = '0;
            mst_addr[i] = '0; mst_wstrb[i] = '0; mst_wdata[i] = '0;
        end
        clearModel();
        #1;
        resetn    = 1'b0;
        m_req     = '1;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_s_req", s_req, 0);
        checkOutput("rst_addr_ok", m_addr_ok, 0);
        checkOutput("rst_data_ok", m_data_ok, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_proto_err", proto_err, 0);
        clearModel();
        @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(60, 70, 40);
            mon_en = 1'b1;
        end

        // Build up outstanding requests, then reset in the middle of them.
        for (int k = 0; k < 50 && owner_q.size() < 2; k++) begin
            @(posedge clk);
            #1;
            applyStimulus(90, 90, 0);
        end
        @(posedge clk);
        #1;
        mon_en    = 1'b0;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        resetn    = 1'b0;
        #1;
        checkOutput("midrst_outstanding", outstanding, 0);
        checkOutput("midrst_s_req", s_req, 0);
        checkOutput("midrst_addr_ok", m_addr_ok, 0);
        checkOutput("midrst_data_ok", m_data_ok, 0);
        checkOutput("midrst_proto_err", proto_err, 0);
        clearModel();
        @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(80, 80, 50);
            mon_en = 1'b1;
        end
        for (int c = 0; c < 300 && (owner_q.size() > 0 || anyBusy()); c++) begin
            @(posedge clk);
            #1;
            applyStimulus(0, 80, 100);
        end

        // Response with nothing outstanding: no pulse, sticky error.
        @(posedge clk);
        #1;
        mon_en      = 1'b0;
        m_req       = '0;
        s_addr_ok   = 1'b0;
        s_data_ok   = 1'b1;
        f_s_data_ok = fix_pending;
        fix_pending = 1'b0;
        #3;
        checkOutput("drained_outstanding", outstanding, 0);
        checkOutput("spurious_data_ok", m_data_ok, 0);
        @(posedge clk);
        #1;
        s_data_ok   = 1'b0;
        f_s_data_ok = 1'b0;
        checkOutput("proto_err_set", proto_err, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("proto_err_held", proto_err, 1);
        checkOutput("spurious_outstanding", outstanding, 0);
        checkOutput("acc_q_left", acc_q.size(), 0);
        checkOutput("rsp_q_left", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-master to 1-slave arbiter for the CPU's SRAM-like (req/addr_ok/data_ok) bus. Sits between the pipeline's fetch, load/store and future cache ports and the single SRAM-like port feeding the AXI bridge. It replaces the fixed two-port inst/data split with configurable master count, arbitration mode and outstanding depth. Responses return strictly in order.

## Interface
Parameters:
- NUM_MASTERS, 2, number of master ports (2..8); index 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MAX_OUTSTANDING, 4, depth of the owner-tracking FIFO (power of 2, 2..16).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- m_req  in  NUM_MASTERS  per-master request.
- m_wr  in  NUM_MASTERS  per-master write flag.
- m_size  in  2*NUM_MASTERS  per-master size (0 = byte, 1 = half, 2 = word).
- m_addr  in  ADDR_W*NUM_MASTERS  per-master address.
- m_wstrb  in  (DATA_W/8)*NUM_MASTERS  per-master byte strobes.
- m_wdata  in  DATA_W*NUM_MASTERS  per-master write data.
- m_addr_ok  out  NUM_MASTERS  request accepted; one-hot or zero.
- m_data_ok  out  NUM_MASTERS  response for that master; one-hot or zero.
- m_rdata  out  DATA_W  read data, broadcast to all masters.
- s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata  out  1/1/2/ADDR_W/DATA_W/8/DATA_W  forwarded request of the granted master.
- s_addr_ok  in  1  slave accepts the request.
- s_data_ok  in  1  slave returns a response.
- s_rdata  in  DATA_W  slave read data.
- outstanding  out  clog2(MAX_OUTSTANDING)+1  number of accepted requests not yet answered.
- proto_err  out  1  sticky: s_data_ok arrived with nothing outstanding.

## Operation
- Grant is combinational from m_req and the priority pointer.
  - Round-robin: the first requesting master at or after ptr, wrapping modulo NUM_MASTERS.
  - Fixed: the lowest-indexed requesting master.
- s_req = |m_req & ~full & resetn. The s_* payload is a mux of the granted master's fields; all zero when no master is requesting.
- Accept event: s_req & s_addr_ok.
  - m_addr_ok[grant] = 1 in the same cycle.
  - The grant index is pushed into the owner FIFO.
  - In round-robin mode, ptr <= (grant+1) mod NUM_MASTERS. ptr is unchanged when no accept occurs, and is never updated in fixed mode.
- Response event: s_data_ok & ~empty.
  - m_data_ok[head] = 1 and m_rdata = s_rdata combinationally.
  - The FIFO head is popped.
- Simultaneous accept and response: push and pop happen together and outstanding is unchanged.
- Full (outstanding == MAX_OUTSTANDING): s_req = 0 and no m_addr_ok, even if a pop occurs in the same cycle.
- Empty with s_data_ok = 1: no m_data_ok pulse, no pop, proto_err <= 1 (cleared only by reset).
- Masters must hold their req and payload stable until addr_ok. A losing master simply waits; it is not dropped.
- The slave must not return data_ok for a request in the same cycle as that request's addr_ok.
- Reset mid-operation: all tracked requests are discarded. Responses the slave issues afterwards set proto_err.

## Timing
- Request path is zero latency: m_* to s_* and s_addr_ok to m_addr_ok are combinational.
- Response path is zero latency: s_data_ok/s_rdata to m_data_ok/m_rdata are combinational.
- Back-to-back accepts are allowed every cycle until full.
- Reset values: ptr 0, FIFO read/write pointers 0, outstanding 0, proto_err 0.
- Resulting outputs while resetn = 0: s_req 0, m_addr_ok 0, m_data_ok 0.
- FIFO pointers are clog2(MAX_OUTSTANDING)+1 bits wide and wrap naturally. full/empty are decoded from MSB mismatch and pointer equality.

## Test plan
- Single master 0, read at addr 0x1c000000, slave gives addr_ok then data_ok 2 cycles later with 0xdeadbeef → m_addr_ok[0] pulses once, m_data_ok[0] pulses with m_rdata 0xdeadbeef, outstanding goes 0→1→0.
- ARB_MODE 0, masters 0 and 1 requesting continuously, s_addr_ok held at 1 → grants alternate 0,1,0,1. With ARB_MODE 1 → grants are always 0.
- MAX_OUTSTANDING 4, s_addr_ok = 1, s_data_ok held at 0 → exactly 4 accepts, then s_req = 0. One data_ok → one further accept in the cycle after the pop.
- Interleaved owners 1,0,1 accepted, then three data_ok pulses with values 0x11/0x22/0x33 → m_data_ok one-hot sequence 1,0,1 carrying those values in order.
- s_data_ok with outstanding 0 → no m_data_ok, proto_err = 1 from the next cycle and held. Assert resetn = 0 → proto_err, outstanding and s_req all 0 immediately.
- Same-cycle accept and response at outstanding 2 → outstanding stays 2, FIFO order preserved.
